// File: rtl/multicycle_ctrl_pkg.sv
// ctrl_pkg: shared FSM states, RV32 opcodes and select encodings for multicycle_ctrl.
// Revision: 1.0
`default_nettype none

package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    typedef struct packed {
        logic [2:0] funct3;
        logic [6:0] opcode;
    } op_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] IMM_NONE = 2'd0;
    localparam logic [1:0] IMM_I    = 2'd1;
    localparam logic [1:0] IMM_S    = 2'd2;
    localparam logic [1:0] IMM_B    = 2'd3;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    function automatic logic [1:0] imm_sel_of(input logic [6:0] opcode);
        logic [1:0] sel;
        sel = IMM_NONE;
        case (opcode)
            OP_IMM, OP_LOAD: sel = IMM_I;
            OP_STORE:        sel = IMM_S;
            OP_BRANCH:       sel = IMM_B;
            default:         sel = IMM_NONE;
        endcase
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control/status bundle between the sequencer and the RV32 datapath.
// Revision: 1.0
`default_nettype none

interface multicycle_ctrl_if;
    logic        start_i;
    logic [31:0] instr_i;
    logic        zero_i;
    logic        mem_ack_i;
    logic        pc_we_o;
    logic        pc_src_o;
    logic        ir_we_o;
    logic [1:0]  imm_sel_o;
    logic        alu_src_o;
    logic [1:0]  alu_op_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic        reg_we_o;
    logic        mem_to_reg_o;
    logic        illegal_o;
    logic [31:0] cycle_o;
    logic [31:0] instret_o;

    modport master (
        input  start_i, instr_i, zero_i, mem_ack_i,
        output pc_we_o, pc_src_o, ir_we_o, imm_sel_o, alu_src_o, alu_op_o,
               mem_req_o, mem_we_o, reg_we_o, mem_to_reg_o, illegal_o,
               cycle_o, instret_o
    );

    modport slave (
        output start_i, instr_i, zero_i, mem_ack_i,
        input  pc_we_o, pc_src_o, ir_we_o, imm_sel_o, alu_src_o, alu_op_o,
               mem_req_o, mem_we_o, reg_we_o, mem_to_reg_o, illegal_o,
               cycle_o, instret_o
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl_perf_cnt.sv
// ctrl_perf_cnt: active-cycle and retired-instruction counters (built only with CTRL_PERF_CNT_EN).
// Revision: 1.0
`default_nettype none

`ifdef CTRL_PERF_CNT_EN
module ctrl_perf_cnt (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        i_active,
    input  wire logic        i_retire,
    output logic [31:0]      o_cycle,
    output logic [31:0]      o_instret
);
    logic [31:0] r_cycle;
    logic [31:0] r_instret;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            if (i_active) r_cycle   <= r_cycle + 32'd1;
            if (i_retire) r_instret <= r_instret + 32'd1;
        end
    end

    assign o_cycle   = r_cycle;
    assign o_instret = r_instret;
endmodule
`endif

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 multi-cycle datapath.
// Optional macro CTRL_PERF_CNT_EN enables the cycle/instret counters. Revision: 1.0
`default_nettype none

module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    multicycle_ctrl_if.master bus
);
    state_t      r_state, w_next;
    op_t         r_op, w_op_d;
    logic        w_pc_we, w_pc_src, w_ir_we, w_alu_src, w_mem_req, w_mem_we;
    logic        w_reg_we, w_mem_to_reg, w_illegal, w_legal, w_active;
    logic [1:0]  w_imm_sel, w_alu_op;
    logic [31:0] w_cycle, w_instret;
    state_t      w_boundary;
    logic        w_unused_instr;

    assign w_unused_instr = ^{bus.instr_i[31:15], bus.instr_i[11:7]};
    assign w_boundary     = bus.start_i ? ST_FETCH : ST_IDLE;

    always_comb begin
        w_legal = 1'b0;
        case (bus.instr_i[6:0])
            OP_R, OP_IMM, OP_LOAD, OP_STORE: w_legal = 1'b1;
            OP_BRANCH: w_legal = (bus.instr_i[14:12] == 3'b000);
            default:   w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            r_op    <= w_op_d;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_op_d       = r_op;
        w_pc_we      = 1'b0;
        w_pc_src     = 1'b0;
        w_ir_we      = 1'b0;
        w_imm_sel    = IMM_NONE;
        w_alu_src    = 1'b0;
        w_alu_op     = ALU_ADD;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_reg_we     = 1'b0;
        w_mem_to_reg = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start_i) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_ir_we = 1'b1;
                w_next  = ST_DECODE;
            end
            ST_DECODE: begin
                w_op_d    = '{funct3: bus.instr_i[14:12], opcode: bus.instr_i[6:0]};
                w_imm_sel = imm_sel_of(bus.instr_i[6:0]);
                if (w_legal) begin
                    w_next = ST_EXEC;
                end else begin
                    w_illegal = 1'b1;
                    w_pc_we   = 1'b1;
                    w_next    = w_boundary;
                end
            end
            ST_EXEC: begin
                w_imm_sel = imm_sel_of(r_op.opcode);
                case (r_op.opcode)
                    OP_R: begin
                        w_alu_op = ALU_FUNCT;
                        w_next   = ST_WB;
                    end
                    OP_IMM: begin
                        w_alu_op  = ALU_FUNCT;
                        w_alu_src = 1'b1;
                        w_next    = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        w_alu_src = 1'b1;
                        w_next    = ST_MEM;
                    end
                    default: begin
                        // Only BEQ reaches here; it resolves and retires in this cycle.
                        w_alu_op = ALU_SUB;
                        w_pc_we  = 1'b1;
                        w_pc_src = bus.zero_i;
                        w_next   = w_boundary;
                    end
                endcase
            end
            ST_MEM: begin
                w_mem_req = 1'b1;
                w_mem_we  = (r_op.opcode == OP_STORE);
                if (bus.mem_ack_i) begin
                    if (r_op.opcode == OP_LOAD) begin
                        w_next = ST_WB;
                    end else begin
                        w_pc_we = 1'b1;
                        w_next  = w_boundary;
                    end
                end
            end
            ST_WB: begin
                w_reg_we     = 1'b1;
                w_mem_to_reg = (r_op.opcode == OP_LOAD);
                w_pc_we      = 1'b1;
                w_next       = w_boundary;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_active = (r_state != ST_IDLE);

`ifdef CTRL_PERF_CNT_EN
    ctrl_perf_cnt u_perf_cnt (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .i_active  (w_active),
        .i_retire  (w_pc_we),
        .o_cycle   (w_cycle),
        .o_instret (w_instret)
    );
`else
    logic w_unused_perf;
    assign w_unused_perf = w_active;
    assign w_cycle       = '0;
    assign w_instret     = '0;
`endif

    assign bus.pc_we_o      = w_pc_we;
    assign bus.pc_src_o     = w_pc_src;
    assign bus.ir_we_o      = w_ir_we;
    assign bus.imm_sel_o    = w_imm_sel;
    assign bus.alu_src_o    = w_alu_src;
    assign bus.alu_op_o     = w_alu_op;
    assign bus.mem_req_o    = w_mem_req;
    assign bus.mem_we_o     = w_mem_we;
    assign bus.reg_we_o     = w_reg_we;
    assign bus.mem_to_reg_o = w_mem_to_reg;
    assign bus.illegal_o    = w_illegal;
    assign bus.cycle_o      = w_cycle;
    assign bus.instret_o    = w_instret;
endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl.
// Revision: 1.0
`default_nettype none

module tb_multicycle_ctrl;
    logic clk_i;
    logic rst_i;
    int   n_checks;
    int   n_errors;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    localparam logic [31:0] I_ADDI  = 32'h0050_0093;
    localparam logic [31:0] I_SW    = 32'h0011_2223;
    localparam logic [31:0] I_LW    = 32'h0001_2083;
    localparam logic [31:0] I_BEQ   = 32'h0020_8463;
    localparam logic [31:0] I_BNE   = 32'h0020_9463;
    localparam logic [31:0] I_BAD   = 32'h0000_007F;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {pc_we, pc_src, ir_we, imm_sel, alu_src, alu_op, mem_req, mem_we, reg_we, mem_to_reg, illegal}
    function automatic logic [12:0] v(input bit pw, input bit ps, input bit ir,
                                      input logic [1:0] imm, input bit as, input logic [1:0] op,
                                      input bit rq, input bit wr, input bit rw, input bit m2,
                                      input bit il);
        return {pw, ps, ir, imm, as, op, rq, wr, rw, m2, il};
    endfunction

    function automatic logic [12:0] outs();
        return {bus.pc_we_o, bus.pc_src_o, bus.ir_we_o, bus.imm_sel_o, bus.alu_src_o,
                bus.alu_op_o, bus.mem_req_o, bus.mem_we_o, bus.reg_we_o,
                bus.mem_to_reg_o, bus.illegal_o};
    endfunction

    function automatic logic [31:0] perf(input logic [31:0] x);
`ifdef CTRL_PERF_CNT_EN
        return x;
`else
        return 32'd0 & x;
`endif
    endfunction

    // Check this cycle's outputs, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic [12:0] exp);
        #1;
        check(tag, {19'd0, outs()}, {19'd0, exp});
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] cyc_n, input logic [31:0] ret_n);
        check({tag, "_cycle"}, bus.cycle_o, perf(cyc_n));
        check({tag, "_instret"}, bus.instret_o, perf(ret_n));
    endtask

    localparam logic [12:0] V_IDLE  = 13'd0;

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_i         = 1'b0;
        bus.start_i   = 1'b0;
        bus.instr_i   = 32'd0;
        bus.zero_i    = 1'b0;
        bus.mem_ack_i = 1'b0;

        repeat (2) @(posedge clk_i);
        #1;
        check("reset_outs", {19'd0, outs()}, 32'd0);
        check("reset_cycle", bus.cycle_o, 32'd0);
        check("reset_instret", bus.instret_o, 32'd0);

        @(negedge clk_i);
        rst_i       = 1'b1;
        bus.start_i = 1'b1;
        bus.instr_i = I_ADDI;
        @(posedge clk_i);
        #1;

        // ADDI: 4 cycles
        cyc("addi_fetch",  v(0,0,1, 2'd0, 0, 2'd0, 0,0,0,0,0));
        cyc("addi_decode", v(0,0,0, 2'd1, 0, 2'd0, 0,0,0,0,0));
        cyc("addi_exec",   v(0,0,0, 2'd1, 1, 2'd2, 0,0,0,0,0));
        cyc("addi_wb",     v(1,0,0, 2'd0, 0, 2'd0, 0,0,1,0,0));
        check_cnt("after_addi", 32'd4, 32'd1);

        // SW with three wait cycles; an ack during DECODE must be ignored
        bus.instr_i = I_SW;
        cyc("sw_fetch",  v(0,0,1, 2'd0, 0, 2'd0, 0,0,0,0,0));
        bus.mem_ack_i = 1'b1;
        cyc("sw_decode", v(0,0,0, 2'd2, 0, 2'd0, 0,0,0,0,0));
        bus.mem_ack_i = 1'b0;
        cyc("sw_exec",   v(0,0,0, 2'd2, 1, 2'd0, 0,0,0,0,0));
        for (int i = 0; i < 3; i++)
            cyc("sw_mem_wait", v(0,0,0, 2'd0, 0, 2'd0, 1,1,0,0,0));
        bus.mem_ack_i = 1'b1;
        cyc("sw_mem_ack", v(1,0,0, 2'd0, 0, 2'd0, 1,1,0,0,0));
        bus.mem_ack_i = 1'b0;
        check_cnt("after_sw", 32'd11, 32'd2);

        // LW with ack in the first MEM cycle
        bus.instr_i = I_LW;
        cyc("lw_fetch",  v(0,0,1, 2'd0, 0, 2'd0, 0,0,0,0,0));
        cyc("lw_decode", v(0,0,0, 2'd1, 0, 2'd0, 0,0,0,0,0));
        cyc("lw_exec",   v(0,0,0, 2'd1, 1, 2'd0, 0,0,0,0,0));
        bus.mem_ack_i = 1'b1;
        cyc("lw_mem",    v(0,0,0, 2'd0, 0, 2'd0, 1,0,0,0,0));
        bus.mem_ack_i = 1'b0;
        cyc("lw_wb",     v(1,0,0, 2'd0, 0, 2'd0, 0,0,1,1,0));
        check_cnt("after_lw", 32'd16, 32'd3);

        // BEQ taken then not taken
        bus.instr_i = I_BEQ;
        bus.zero_i  = 1'b1;
        cyc("beq_t_fetch",  v(0,0,1, 2'd0, 0, 2'd0, 0,0,0,0,0));
        cyc("beq_t_decode", v(0,0,0, 2'd3, 0, 2'd0, 0,0,0,0,0));
        cyc("beq_t_exec",   v(1,1,0, 2'd3, 0, 2'd1, 0,0,0,0,0));
        bus.zero_i  = 1'b0;
        cyc("beq_n_fetch",  v(0,0,1, 2'd0, 0, 2'd0, 0,0,0,0,0));
        cyc("beq_n_decode", v(0,0,0, 2'd3, 0, 2'd0, 0,0,0,0,0));
        cyc("beq_n_exec",   v(1,0,0, 2'd3, 0, 2'd1, 0,0,0,0,0));
        check_cnt("after_beq", 32'd22, 32'd5);

        // Unsupported opcode, then BRANCH with funct3 != 0
        bus.instr_i = I_BAD;
        cyc("bad_fetch",  v(0,0,1, 2'd0, 0, 2'd0, 0,0,0,0,0));
        cyc("bad_decode", v(1,0,0, 2'd0, 0, 2'd0, 0,0,0,0,1));
        bus.instr_i = I_BNE;
        cyc("bne_fetch",  v(0,0,1, 2'd0, 0, 2'd0, 0,0,0,0,0));
        cyc("bne_decode", v(1,0,0, 2'd3, 0, 2'd0, 0,0,0,0,1));
        check_cnt("after_illegal", 32'd26, 32'd7);

        // start_i dropped mid-instruction: ADDI completes, then IDLE
        bus.instr_i = I_ADDI;
        bus.start_i = 1'b0;
        cyc("stop_fetch",  v(0,0,1, 2'd0, 0, 2'd0, 0,0,0,0,0));
        cyc("stop_decode", v(0,0,0, 2'd1, 0, 2'd0, 0,0,0,0,0));
        cyc("stop_exec",   v(0,0,0, 2'd1, 1, 2'd2, 0,0,0,0,0));
        cyc("stop_wb",     v(1,0,0, 2'd0, 0, 2'd0, 0,0,1,0,0));
        cyc("stop_idle0",  V_IDLE);
        cyc("stop_idle1",  V_IDLE);
        check_cnt("after_stop", 32'd30, 32'd8);

        // Asynchronous reset in the middle of a pending store
        bus.instr_i = I_SW;
        bus.start_i = 1'b1;
        cyc("rst_idle",   V_IDLE);
        cyc("rst_fetch",  v(0,0,1, 2'd0, 0, 2'd0, 0,0,0,0,0));
        cyc("rst_decode", v(0,0,0, 2'd2, 0, 2'd0, 0,0,0,0,0));
        cyc("rst_exec",   v(0,0,0, 2'd2, 1, 2'd0, 0,0,0,0,0));
        #1;
        check("rst_mem_req", {31'd0, bus.mem_req_o}, 32'd1);
        #1;
        rst_i = 1'b0;
        #1;
        check("rst_async_outs", {19'd0, outs()}, 32'd0);
        check("rst_async_cycle", bus.cycle_o, 32'd0);
        check("rst_async_instret", bus.instret_o, 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("rst_then_fetch", {19'd0, outs()}, {19'd0, v(0,0,1, 2'd0, 0, 2'd0, 0,0,0,0,0)});
        check("rst_then_cycle", bus.cycle_o, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
